// File: rtl/pulse_pacer_pkg.sv
// Shared types and helpers for the pulse pacer: FSM state encoding and
// the sizing rule for the inter-pulse gap counter.
package pulse_pacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Smallest width that can hold MIN_GAP-2, never less than one bit.
    function automatic int gap_cnt_width(input int min_gap);
        int w;
        w = 1;
        while ((1 << w) < (min_gap - 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter. An increment that would wrap past all-ones is
// dropped and reported on o_drop for the same cycle.
module sat_updown_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_count_next,
    output logic         o_drop
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_next;
    logic         w_drop;

    always_comb begin
        w_count_next = r_count;
        w_drop       = 1'b0;
        if (i_inc && !i_dec) begin
            if (r_count == MAX_VAL) begin
                w_drop = 1'b1;
            end else begin
                w_count_next = r_count + W'(1);
            end
        end else if (!i_inc && i_dec && (r_count != '0)) begin
            w_count_next = r_count - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_drop       = w_drop;

endmodule

// File: rtl/pulse_pacer.sv
// Converts bursty one-cycle event strobes into single-cycle pulses spaced
// MIN_GAP clocks apart, with a saturating backlog and sticky overflow flag.
module pulse_pacer
    import pulse_pacer_pkg::*;
#(
    parameter int MIN_GAP = 6,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_in,
    input  logic             ovf_clr,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf
);

    localparam int                 GAP_W    = gap_cnt_width(MIN_GAP);
    localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(MIN_GAP - 2);

    state_e           r_state;
    state_e           w_state_next;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [GAP_W-1:0] w_gap_cnt_next;
    logic             r_pulse;
    logic             r_busy;
    logic             r_ovf;
    logic             w_dec;
    logic             w_drop;
    logic [CNT_W-1:0] w_pending;
    logic [CNT_W-1:0] w_pending_next;

    sat_updown_cnt #(
        .W (CNT_W)
    ) u_backlog (
        .clk          (clk),
        .rst          (rst),
        .i_inc        (req_in),
        .i_dec        (w_dec),
        .o_count      (w_pending),
        .o_count_next (w_pending_next),
        .o_drop       (w_drop)
    );

    // The backlog decrements on exactly the edge that enters FIRE.
    always_comb begin
        w_state_next   = r_state;
        w_gap_cnt_next = r_gap_cnt;
        w_dec          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending != '0) begin
                    w_state_next = ST_FIRE;
                    w_dec        = 1'b1;
                end
            end
            ST_FIRE: begin
                w_state_next   = ST_GAP;
                w_gap_cnt_next = GAP_LOAD;
            end
            ST_GAP: begin
                if (r_gap_cnt != '0) begin
                    w_gap_cnt_next = r_gap_cnt - GAP_W'(1);
                end else if (w_pending != '0) begin
                    w_state_next = ST_FIRE;
                    w_dec        = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next   = ST_IDLE;
                w_gap_cnt_next = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= '0;
            r_pulse   <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_gap_cnt <= w_gap_cnt_next;
            r_pulse   <= (w_state_next == ST_FIRE);
            r_busy    <= (w_state_next != ST_IDLE) || (w_pending_next != '0);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign pulse_out = r_pulse;
    assign pending   = w_pending;
    assign busy      = r_busy;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pulse_pacer.sv
// Randomised and directed stimulus for pulse_pacer, checked cycle by cycle
// against a timing-rule reference model through a scoreboard queue.
module tb_pulse_pacer;

    localparam int MIN_GAP = 6;
    localparam int CNT_W   = 4;
    localparam int MAXP    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_in;
    logic             ovf_clr;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;

    pulse_pacer #(
        .MIN_GAP (MIN_GAP),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .ovf_clr   (ovf_clr),
        .pulse_out (pulse_out),
        .pending   (pending),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        bit pulse;
        int pend;
        bit busy;
        bit ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   dut_pulses = 0;
    int   mdl_pulses = 0;

    // Reference model: pending backlog, sticky flag, time of the last pulse.
    int m_pend = 0;
    bit m_ovf  = 1'b0;
    int m_last = -1000;

    task automatic chk(input string name, input int t, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, t, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input bit r, input bit c, input bit s);
        exp_t e;
        int   t;
        int   n;
        bit   fire;
        bit   drop;
        rst     = s;
        req_in  = r;
        ovf_clr = c;
        t       = cyc + 1;
        e.t     = t;
        if (s) begin
            m_pend = 0;
            m_ovf  = 1'b0;
            m_last = -1000;
            e.pulse = 1'b0;
            e.pend  = 0;
            e.busy  = 1'b0;
            e.ovf   = 1'b0;
        end else begin
            fire = (m_pend > 0) && ((t - m_last) >= MIN_GAP);
            n    = m_pend + int'(r) - int'(fire);
            drop = (n > MAXP);
            if (drop) n = MAXP;
            if (drop) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (fire) begin
                m_last = t;
                mdl_pulses++;
            end
            m_pend  = n;
            e.pulse = fire;
            e.pend  = n;
            e.busy  = (n > 0) || ((t - m_last) < MIN_GAP);
            e.ovf   = m_ovf;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic reqs(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare every cycle the DUT has an expected observation queued.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].t <= cyc) begin
            e = sb_q.pop_front();
            if (pulse_out) dut_pulses++;
            chk("pulse_out", e.t, int'(pulse_out), int'(e.pulse));
            chk("pending",   e.t, int'(pending),   e.pend);
            chk("busy",      e.t, int'(busy),      int'(e.busy));
            chk("ovf",       e.t, int'(ovf),       int'(e.ovf));
        end
    end

    initial begin : stim
        int rate;
        rst     = 1'b1;
        req_in  = 1'b0;
        ovf_clr = 1'b0;

        // Reset, then single event in relative cycle 10.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        idle(10); reqs(1); idle(30);

        // Short burst of three.
        step(1'b0, 1'b0, 1'b1);
        idle(10); reqs(3); idle(30);

        // Overflow, then clear racing a new drop, then clear alone.
        step(1'b0, 1'b0, 1'b1);
        idle(10); reqs(20);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(130);

        // Reset in the middle of a burst.
        step(1'b0, 1'b0, 1'b1);
        idle(10); reqs(3);
        step(1'b0, 1'b0, 1'b1);
        idle(30);

        // Randomised segments with varying event density.
        rate = 20;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                case ($urandom_range(0, 3))
                    0: rate = 5;
                    1: rate = 20;
                    2: rate = 50;
                    default: rate = 95;
                endcase
            end
            step($urandom_range(0, 99) < rate,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 999) < 5);
        end
        idle(100);

        @(negedge clk);
        #1;
        chk("sb_drain", cyc, sb_q.size(), 0);
        chk("pulse_total", cyc, dut_pulses, mdl_pulses);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
